// File: rtl/norm_shift.sv
// Two-stage left normalizer for the MAF path: moves the leading one to bit 31
// and rebases the exponent, clamping at exponent 0 to form a denormal.
module norm_shift #(
    parameter int WIDTH = 32,
    parameter int POS_W = 5,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [POS_W-1:0] in_pos,
    input  logic             in_pos_v,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_denorm
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [2:0]       fine;
        logic [EXP_W-1:0] exp;
        logic             zero;
        logic             denorm;
    } s1_t;

    s1_t              s1_d, s1_q;
    logic             s1_valid;
    logic             s2_adv;
    logic             in_xfer;
    logic [POS_W-1:0] shift;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_xfer  = in_valid && in_ready;

    // Shift amount is the lzc, unless that would drive the exponent below 0.
    always_comb begin
        shift       = '0;
        s1_d        = '0;
        s1_d.zero   = 1'b1;
        if (in_pos_v) begin
            s1_d.zero = 1'b0;
            if (in_exp >= EXP_W'(in_pos)) begin
                shift    = in_pos;
                s1_d.exp = in_exp - EXP_W'(in_pos);
            end else begin
                shift       = in_exp[POS_W-1:0];
                s1_d.denorm = 1'b1;
            end
            s1_d.data = in_data << {shift[4:3], 3'b000};
            s1_d.fine = shift[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output registers only move when downstream can take a beat, so they hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_exp    <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= s1_q.data << s1_q.fine;
                out_exp    <= s1_q.exp;
                out_zero   <= s1_q.zero;
                out_denorm <= s1_q.denorm;
            end
        end
    end

endmodule

// File: tb/tb_norm_shift.sv
// Scoreboard bench for norm_shift: directed cases, backpressure, throughput, mid-stream reset.
module tb_norm_shift;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  exp;
        logic        zero;
        logic        denorm;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_pos_v, out_valid, out_ready, out_zero, out_denorm;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_pos;
    logic [7:0]  in_exp, out_exp;

    int          total = 0;
    int          passed = 0;
    res_t        sb[$];
    res_t        mon_e;
    logic [41:0] snap;
    logic [31:0] rd;
    logic [4:0]  rp;
    logic [7:0]  re;

    norm_shift #(.WIDTH(32), .POS_W(5), .EXP_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pos(in_pos), .in_pos_v(in_pos_v), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_exp(out_exp), .out_zero(out_zero), .out_denorm(out_denorm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic res_t mk(logic [31:0] d, logic [7:0] e, logic z, logic dn);
        res_t r;
        r.data = d; r.exp = e; r.zero = z; r.denorm = dn;
        return r;
    endfunction

    // Reference: one full-width shift, independent of the two-stage split.
    function automatic res_t model(logic [31:0] d, logic [4:0] p, logic pv, logic [7:0] e);
        res_t r = '0;
        if (!pv) r.zero = 1'b1;
        else if (e >= {3'b000, p}) begin
            r.data = d << p;
            r.exp  = e - {3'b000, p};
        end else begin
            r.data   = d << e;
            r.denorm = 1'b1;
        end
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [4:0] p, input logic pv,
                        input logic [7:0] e, input res_t expv);
        int waited = 0;
        in_valid = 1'b1; in_data = d; in_pos = p; in_pos_v = pv; in_exp = e;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 100) check("accept_timeout_in_ready", 64'(in_ready), 64'd1);
        else sb.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("beat", 64'({out_data, out_exp, out_zero, out_denorm}), 64'(mon_e));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_pos = '0; in_pos_v = 1'b0;
        in_exp = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bus", 64'({out_data, out_exp, out_zero, out_denorm}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        step();

        // Directed cases
        send(32'h0000_1234, 5'd19, 1'b1, 8'd100, mk(32'h91A0_0000, 8'd81, 1'b0, 1'b0));
        @(negedge clk);
        check("lat_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_out_valid", 64'(out_valid), 64'd1);
        step();
        send(32'h0000_1234, 5'd19, 1'b1, 8'd5,   mk(32'h0002_4680, 8'd0, 1'b0, 1'b1));
        send(32'h0000_0000, 5'd0,  1'b0, 8'd77,  mk(32'h0000_0000, 8'd0, 1'b1, 1'b0));
        send(32'h8000_0000, 5'd0,  1'b1, 8'd0,   mk(32'h8000_0000, 8'd0, 1'b0, 1'b0));
        send(32'h0000_0001, 5'd31, 1'b1, 8'd31,  mk(32'h8000_0000, 8'd0, 1'b0, 1'b0));
        send(32'h0000_0001, 5'd31, 1'b1, 8'd255, mk(32'h8000_0000, 8'd224, 1'b0, 1'b0));
        drain();
        step();

        // Backpressure: stall 4 cycles from the first out_valid
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    rp = 5'(3 + i * 5);
                    rd = (32'h8000_0000 >> rp) | 32'(i);
                    re = 8'(40 + i * 3);
                    send(rd, rp, 1'b1, re, model(rd, rp, 1'b1, re));
                end
            end
            begin
                int n = 0;
                while (!out_valid && n < 50) begin
                    n++;
                    step();
                end
                check("bp_first_out_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b0;
                snap = {out_data, out_exp, out_zero, out_denorm};
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_stall_stable", 64'({out_data, out_exp, out_zero, out_denorm, out_valid}),
                          64'({snap, 1'b1}));
                    if (k == 3) check("bp_in_ready_low", 64'(in_ready), 64'd0);
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        step();

        // Throughput: 16 back-to-back random beats
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    rp = 5'($urandom_range(31));
                    rd = (32'h8000_0000 >> rp) | ($urandom() & ((32'h8000_0000 >> rp) - 32'd1));
                    re = 8'($urandom_range(255));
                    send(rd, rp, 1'b1, re, model(rd, rp, 1'b1, re));
                end
            end
            begin
                int n = 0;
                int run = 0;
                while (!out_valid && n < 60) begin
                    n++;
                    @(negedge clk);
                end
                while (out_valid && run < 40) begin
                    run++;
                    @(negedge clk);
                end
                check("tput_run_length", 64'(run), 64'd16);
            end
        join
        drain();
        step();

        // Reset with both stages full
        out_ready = 1'b0;
        send(32'h0001_0000, 5'd15, 1'b1, 8'd20, mk(32'h8000_0000, 8'd5, 1'b0, 1'b0));
        send(32'h0000_00F0, 5'd24, 1'b1, 8'd30, mk(32'hF000_0000, 8'd6, 1'b0, 1'b0));
        check("mid_full_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        step();
        send(32'h0000_0300, 5'd22, 1'b1, 8'd200, mk(32'hC000_0000, 8'd178, 1'b0, 1'b0));
        @(negedge clk);
        check("post_rst_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("post_rst_cycle2_out_valid", 64'(out_valid), 64'd1);
        drain();
        step();
        repeat (3) @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/norm_shift.md
Name: norm_shift

Overview:
- Consumer side of the leading-one encoder interface. Takes a 32-bit magnitude, its leading-zero count and valid flag (P, V), and a biased exponent.
- Left-normalizes the magnitude so the leading one lands at bit 31, and adjusts the exponent to match.
- Clamps at exponent 0, which produces a denormal result.
- Sits after the First_one stage in the MAF normalization path. It is a 2-stage valid/ready pipeline.

Parameters:
- WIDTH, 32, magnitude width; only 32 is supported.
- POS_W, 5, width of the position/shift field (log2 WIDTH).
- EXP_W, 8, biased exponent width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  magnitude to normalize.
- in_pos  in  POS_W  leading-zero count: the leading one is at bit 31-in_pos.
- in_pos_v  in  1  a one exists in in_data; 0 means in_data is zero.
- in_exp  in  EXP_W  biased exponent of in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  normalized magnitude.
- out_exp  out  EXP_W  adjusted exponent.
- out_zero  out  1  result is zero.
- out_denorm  out  1  exponent clamped; result is not fully normalized.

Behaviour:
- Reset, asynchronous on rst_n low:
  - s1_valid, out_valid = 0.
  - All data/exp/flag registers = 0.
  - in_ready = 1 after reset release.
- Handshake:
  - A transfer occurs on valid & ready at a rising clk edge.
  - in_ready = !s1_valid | s2_adv, where s2_adv = !out_valid | out_ready.
  - in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
- Stage advance rules:
  - Stage 1 loads on an input transfer.
  - Stage 2 loads from stage 1 when s1_valid & s2_adv.
  - Stage 1 clears s1_valid when it drains with no new input.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid when out_ready is held 1.
  - Throughput 1 beat per cycle.
  - Beats are never reordered, dropped or duplicated.
- Output stability: while out_valid & !out_ready, all out_* hold stable.
- Shift/exponent rule, computed at stage-1 capture (unsigned compare):
  - If in_pos_v=0: shift = 0, exp = 0, zero = 1, denorm = 0, data = 0.
  - Else if in_exp >= in_pos: shift = in_pos, exp = in_exp - in_pos (0 allowed), denorm = 0.
  - Else: shift = in_exp[POS_W-1:0], exp = 0, denorm = 1.
- Shift implementation:
  - Stage 1 registers data << (shift[4:3]*8) plus shift[2:0], exp and flags.
  - Stage 2 registers data << shift[2:0].
  - Zero-fill from the LSB; bits shifted past bit 31 are discarded. A correct in_pos never discards a one.
- Inconsistent input (in_pos_v=1 but bit 31-in_pos of in_data is 0):
  - No error is flagged; the shift is performed as computed.
  - out_data[31] is then not guaranteed to be 1.
- Simultaneous events: stage-2 drain and stage-1 refill in the same cycle is legal and required for full throughput.
- Reset mid-operation: in-flight beats are discarded, and out_valid falls asynchronously.

Test Plan:
- Normal case: in_data=0x0000_1234, in_pos=19, in_pos_v=1, in_exp=100, out_ready=1 -> 2 cycles later out_data=0x91A0_0000, out_exp=81, out_zero=0, out_denorm=0.
- Denormal clamp: in_data=0x0000_1234, in_pos=19, in_exp=5 -> out_data=0x0002_4680, out_exp=0, out_denorm=1.
- Zero input and boundaries:
  - in_data=0, in_pos_v=0, in_exp=77 -> out_data=0, out_exp=0, out_zero=1.
  - in_data=0x8000_0000, in_pos=0, in_exp=0 -> data unchanged, exp 0, denorm=0.
  - in_data=1, in_pos=31, in_exp=31 -> out_data=0x8000_0000, exp 0, denorm=0.
- Backpressure:
  - Stream 5 beats back-to-back and hold out_ready=0 for 4 cycles starting at the first out_valid.
  - Expected: in_ready drops with both stages full, and out_* are stable throughout the stall.
  - Expected after release: all 5 results emerge in order, with no loss or duplication.
- Throughput: 16 consecutive beats with random valid in_pos and in_exp, out_ready=1 -> one result per cycle, matching the reference model each cycle.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 immediately and in_ready=1 after release; the first post-reset beat appears 2 cycles after acceptance, with no stale beats.
